// File: rtl/lcd_bus_rx_pkg.sv
// rtl/lcd_bus_rx_pkg.sv - shared state encodings, instruction constants and err bit indices
package lcd_bus_rx_pkg;

  typedef enum logic [1:0] {
    RX_MODE8   = 2'd0,
    RX_HI_WAIT = 2'd1,
    RX_LO_WAIT = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE   = 2'd0,
    OUT_PEND   = 2'd1,
    OUT_ACKLOW = 2'd2
  } out_state_t;

  localparam logic [8:0] INSTR_CLEAR = 9'h001;
  localparam logic [8:0] INSTR_HOME  = 9'h002;
  localparam logic [8:0] FSET_MASK   = 9'h1f0;
  localparam logic [8:0] FSET_VALUE  = 9'h030;

  localparam int ERR_RW   = 3;
  localparam int ERR_RS   = 2;
  localparam int ERR_BUSY = 1;
  localparam int ERR_OVF  = 0;

  // Return Home ignores bit 0, so 0x002 and 0x003 both take the long busy time
  function automatic logic is_long_instr(input logic [8:0] word);
    return (word == INSTR_CLEAR) || ((word & 9'h1fe) == INSTR_HOME);
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - two-flop pin synchronizer and E falling-edge strobe
module lcd_bus_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       e_pin,
  input  logic       rs_pin,
  input  logic       rw_pin,
  input  logic [3:0] d_pin,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [3:0] d
);

  logic [6:0] meta;
  logic [6:0] sync;
  logic       e_prev;

  // Bus fields are registered alongside the strobe so they line up with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= '0;
      sync   <= '0;
      e_prev <= 1'b0;
      strobe <= 1'b0;
      rs     <= 1'b0;
      rw     <= 1'b0;
      d      <= '0;
    end else begin
      meta   <= {e_pin, rs_pin, rw_pin, d_pin};
      sync   <= meta;
      e_prev <= sync[6];
      strobe <= e_prev & ~sync[6];
      rs     <= sync[5];
      rw     <= sync[4];
      d      <= sync[3:0];
    end
  end

endmodule

// File: rtl/lcd_bus_rx.sv
// rtl/lcd_bus_rx.sv - 4-bit LCD write-bus receiver with busy model and word handshake
module lcd_bus_rx
  import lcd_bus_rx_pkg::*;
#(
  parameter int BUSY_SHORT     = 4000,
  parameter int BUSY_LONG      = 164000,
  parameter int NIBBLE_TIMEOUT = 100000,
  parameter int CW             = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] LCD_D,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  output logic [8:0] data,
  output logic       write,
  input  logic       ack,
  output logic       mode_4bit,
  output logic       busy,
  output logic [3:0] err
);

  localparam logic [CW-1:0] SHORT_CNT = CW'(BUSY_SHORT);
  localparam logic [CW-1:0] LONG_CNT  = CW'(BUSY_LONG);
  localparam logic [CW-1:0] TIMEOUT   = CW'(NIBBLE_TIMEOUT);

  logic       strobe;
  logic       s_rs;
  logic       s_rw;
  logic [3:0] s_d;

  lcd_bus_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .e_pin  (LCD_E),
    .rs_pin (LCD_RS),
    .rw_pin (LCD_RW),
    .d_pin  (LCD_D),
    .strobe (strobe),
    .rs     (s_rs),
    .rw     (s_rw),
    .d      (s_d)
  );

  rx_state_t     rx_state, rx_next;
  out_state_t    out_state, out_next;
  logic [3:0]    hi_nib;
  logic          hi_rs;
  logic [CW-1:0] timer;
  logic [CW-1:0] busy_cnt;
  logic          take;
  logic          hi_load;
  logic          byte_done;
  logic          rs_mis;
  logic [8:0]    word;
  logic          load_out;
  logic          overflow;

  assign take = strobe & ~s_rw;
  assign word = {hi_rs, hi_nib, s_d};

  always_comb begin
    rx_next   = rx_state;
    hi_load   = 1'b0;
    byte_done = 1'b0;
    rs_mis    = 1'b0;
    case (rx_state)
      RX_MODE8: begin
        if (take && !s_rs && s_d == 4'b0010) rx_next = RX_HI_WAIT;
      end
      RX_HI_WAIT: begin
        if (take) begin
          hi_load = 1'b1;
          rx_next = RX_LO_WAIT;
        end
      end
      RX_LO_WAIT: begin
        // a lower-nibble strobe wins over the timeout in the same cycle
        if (take) begin
          if (s_rs == hi_rs) begin
            byte_done = 1'b1;
            rx_next   = ((word & FSET_MASK) == FSET_VALUE) ? RX_MODE8 : RX_HI_WAIT;
          end else begin
            rs_mis  = 1'b1;
            rx_next = RX_HI_WAIT;
          end
        end else if (timer == TIMEOUT) begin
          rx_next = RX_HI_WAIT;
        end
      end
      default: rx_next = RX_MODE8;
    endcase
  end

  always_comb begin
    out_next = out_state;
    load_out = 1'b0;
    overflow = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (byte_done) begin
          load_out = 1'b1;
          out_next = OUT_PEND;
        end
      end
      OUT_PEND:   if (ack)  out_next = OUT_ACKLOW;
      OUT_ACKLOW: if (!ack) out_next = OUT_IDLE;
      default:    out_next = OUT_IDLE;
    endcase
    if (byte_done && out_state != OUT_IDLE) overflow = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state  <= RX_MODE8;
      out_state <= OUT_IDLE;
      hi_nib    <= '0;
      hi_rs     <= 1'b0;
      timer     <= '0;
      busy_cnt  <= '0;
      data      <= '0;
      err       <= '0;
    end else begin
      rx_state  <= rx_next;
      out_state <= out_next;
      if (hi_load) begin
        hi_nib <= s_d;
        hi_rs  <= s_rs;
        timer  <= '0;
      end else if (rx_state == RX_LO_WAIT) begin
        timer <= timer + 1'b1;
      end
      // dropped (overflowed) bytes still occupy the panel
      if (byte_done)
        busy_cnt <= is_long_instr(word) ? LONG_CNT : SHORT_CNT;
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
      if (load_out) data <= word;
      if (strobe && s_rw) err[ERR_RW]   <= 1'b1;
      if (rs_mis)         err[ERR_RS]   <= 1'b1;
      if (strobe && busy) err[ERR_BUSY] <= 1'b1;
      if (overflow)       err[ERR_OVF]  <= 1'b1;
    end
  end

  assign write     = (out_state == OUT_PEND);
  assign mode_4bit = (rx_state != RX_MODE8);
  assign busy      = (busy_cnt != '0);

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb/tb_lcd_bus_rx.sv - directed self-checking bench for lcd_bus_rx
module tb_lcd_bus_rx;

  localparam int BS = 40;
  localparam int BL = 164;
  localparam int NT = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] D     = 4'h0;
  logic       E     = 1'b0;
  logic       RS    = 1'b0;
  logic       RW    = 1'b0;
  logic       ack   = 1'b0;
  logic [8:0] data;
  logic       write;
  logic       mode_4bit;
  logic       busy;
  logic [3:0] err;

  int checks   = 0;
  int failures = 0;
  int n;

  lcd_bus_rx #(
    .BUSY_SHORT     (BS),
    .BUSY_LONG      (BL),
    .NIBBLE_TIMEOUT (NT),
    .CW             (19)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .LCD_D     (D),
    .LCD_E     (E),
    .LCD_RS    (RS),
    .LCD_RW    (RW),
    .data      (data),
    .write     (write),
    .ack       (ack),
    .mode_4bit (mode_4bit),
    .busy      (busy),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ends 3 clocks after E falls: strobe detected, not yet consumed
  task automatic nib_pre(input logic rs, input logic rw, input logic [3:0] d);
    @(posedge clock); #1;
    RS = rs; RW = rw; D = d; E = 1'b1;
    repeat (3) @(posedge clock);
    #1 E = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic nib(input logic rs, input logic [3:0] d);
    nib_pre(rs, 1'b0, d);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; E = 1'b0; RW = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic init_seq();
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h2);
  endtask

  task automatic handshake(input string tag);
    ack = 1'b1;
    @(posedge clock); #1;
    check(tag, write, 1'b0);
    ack = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_busy();
    int k = 0;
    while (busy && k < 500) begin
      @(posedge clock); #1;
      k++;
    end
    check("busy_drop", busy, 1'b0);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_data", data, 9'h000);
    check("rst_write", write, 1'b0);
    check("rst_mode", mode_4bit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 4'h0);
    reset = 1'b0;

    // init sequence
    nib(1'b0, 4'h3);
    check("init_mode_a", mode_4bit, 1'b0);
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h2);
    check("init_mode_b", mode_4bit, 1'b1);
    check("init_write", write, 1'b0);
    check("init_err", err, 4'h0);

    // data 0x41 with output latency and short busy
    nib(1'b1, 4'h4);
    nib_pre(1'b1, 1'b0, 4'h1);
    check("lat_write_lo", write, 1'b0);
    @(posedge clock); #1;
    check("lat_write_hi", write, 1'b1);
    check("w141_data", data, 9'h141);
    check("w141_busy", busy, 1'b1);
    count_busy(n);
    check("busy_short_len", n, BS);
    handshake("w141_ack");

    // function set DL=1 returns to 8-bit mode
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h8);
    check("fset_write", write, 1'b1);
    check("fset_data", data, 9'h038);
    check("fset_mode", mode_4bit, 1'b0);
    handshake("fset_ack");
    wait_busy();
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h1);
    check("mode8_nowrite", write, 1'b0);
    nib(1'b0, 4'h2);
    check("mode8_reenter", mode_4bit, 1'b1);

    // clear display: long busy, then a strobe during home busy
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h1);
    check("clr_data", data, 9'h001);
    check("clr_write", write, 1'b1);
    count_busy(n);
    check("busy_long_len", n, BL);
    handshake("clr_ack");
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h2);
    check("home_data", data, 9'h002);
    handshake("home_ack");
    repeat (20) @(posedge clock);
    #1;
    nib(1'b1, 4'h5);
    check("busy_viol_err", err, 4'b0010);
    wait_busy();
    repeat (NT + 5) @(posedge clock);
    #1;

    // overflow: second word dropped while first unacknowledged
    do_reset();
    init_seq();
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h1);
    wait_busy();
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h2);
    check("ovf_data", data, 9'h141);
    check("ovf_write", write, 1'b1);
    check("ovf_err", err, 4'b0001);
    handshake("ovf_ack");
    wait_busy();

    // rs mismatch, then nibble timeout, then rw strobe ignored
    do_reset();
    init_seq();
    nib(1'b0, 4'h4);
    nib(1'b1, 4'h1);
    check("rsm_err", err, 4'b0100);
    check("rsm_write", write, 1'b0);
    check("rsm_busy", busy, 1'b0);
    nib(1'b0, 4'h4);
    repeat (NT + 1) @(posedge clock);
    #1;
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h8);
    check("tmo_data", data, 9'h148);
    check("tmo_write", write, 1'b1);
    check("tmo_err", err, 4'b0100);
    handshake("tmo_ack");
    wait_busy();
    nib_pre(1'b1, 1'b1, 4'h7);
    @(posedge clock); #1;
    RW = 1'b0;
    check("rw_err", err, 4'b1100);
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h9);
    check("rw_ignored_data", data, 9'h149);
    handshake("rw_ack");
    wait_busy();

    // async reset between nibbles and during PEND
    do_reset();
    init_seq();
    nib(1'b1, 4'h4);
    reset = 1'b1;
    #2;
    check("rst_mid_mode", mode_4bit, 1'b0);
    reset = 1'b0;
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h1);
    check("rst_mid_nowrite", write, 1'b0);
    check("rst_mid_mode8", mode_4bit, 1'b0);
    init_seq();
    nib(1'b1, 4'h4);
    nib(1'b1, 4'h1);
    check("pend_write", write, 1'b1);
    reset = 1'b1;
    #2;
    check("rst_pend_write", write, 1'b0);
    check("rst_pend_data", data, 9'h000);
    check("rst_pend_busy", busy, 1'b0);
    check("rst_pend_mode", mode_4bit, 1'b0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
